stopwatch_centi: RTL and testbench

STOPWATCH_CENTI -- requirements
Module: stopwatch_centi

---
 rtl/stopwatch_centi_pkg.sv | 14 +
 rtl/stopwatch_centi_bcd_digit.sv | 33 +++
 rtl/stopwatch_centi.sv | 96 +++++++++
 tb/tb_stopwatch_centi.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_centi_pkg.sv
// Shared types for the centisecond stopwatch: FSM encoding and BCD digit type.
package stopwatch_centi_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/stopwatch_centi_bcd_digit.sv
// One decade of the display chain: counts 0..MODULUS-1 when enabled and
// raises carry on the enabled step that rolls it back to zero.
module bcd_digit
  import stopwatch_centi_pkg::*;
#(
  parameter int MODULUS = 10
) (
  input  logic clkMHz,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output bcd_t q,
  output logic carry
);

  localparam bcd_t TOP = bcd_t'(MODULUS - 1);

  // Digit register: clear beats enable so a wrap or user clear always lands on zero.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clkMHz) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= (q == TOP) ? '0 : q + bcd_t'(1);
    end
  end

  assign carry = en && (q == TOP);

endmodule

// File: rtl/stopwatch_centi.sv
// Centisecond stopwatch: 100 Hz tick detector, IDLE/RUN/PAUSE control FSM and
// a four-digit BCD ripple-enable chain wrapping at MAX_SEC.99.
module stopwatch_centi
  import stopwatch_centi_pkg::*;
#(
  parameter int MAX_SEC = 59
) (
  input  logic clkMHz,
  input  logic reset,
  input  logic clkHz,
  input  logic start_stop,
  input  logic clear,
  output bcd_t cs_units,
  output bcd_t cs_tens,
  output bcd_t s_units,
  output bcd_t s_tens,
  output logic running,
  output logic ovf
);

  localparam bcd_t S_TENS_TOP  = bcd_t'(MAX_SEC / 10);
  localparam bcd_t S_UNITS_TOP = bcd_t'(MAX_SEC % 10);

  state_t stateQ, stateD;
  logic   clkHzD;
  logic   tick, countEn, clrDigits, wrap;
  logic   csUnitsCarry, csTensCarry, sUnitsCarry, sTensEn;

  // Previous clkHz sample; resets high so a level already high at release is not a tick.
  always_ff @(posedge clkMHz) begin
    if (!reset) clkHzD <= 1'b1;
    else        clkHzD <= clkHz;
  end

  assign tick    = clkHz && !clkHzD;
  assign countEn = tick && (stateQ == RUN);

  // Control state register.
  always_ff @(posedge clkMHz) begin
    if (!reset) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Next-state logic: clear dominates, start_stop toggles between RUN and PAUSE.
  // NOTE: stateD is given a default before any branch so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    stateD = stateQ;
    if (clear) begin
      stateD = IDLE;
    end else if (start_stop) begin
      case (stateQ)
        IDLE:    stateD = RUN;
        RUN:     stateD = PAUSE;
        PAUSE:   stateD = RUN;
        default: stateD = IDLE;
      endcase
    end
  end

  assign running = (stateQ == RUN);

  // The seconds-tens stage is also stepped when units sit at MAX_SEC%10 under a
  // full hundredths carry, so its carry fires exactly on MAX_SEC.99 -> wrap.
  assign sTensEn   = sUnitsCarry ||
                     (csTensCarry && (s_units == S_UNITS_TOP) && (s_tens == S_TENS_TOP));
  assign clrDigits = clear || wrap;

  bcd_digit #(.MODULUS(10)) uCsUnits (
    .clkMHz(clkMHz), .reset(reset), .en(countEn),      .clr(clrDigits),
    .q(cs_units),    .carry(csUnitsCarry)
  );

  bcd_digit #(.MODULUS(10)) uCsTens (
    .clkMHz(clkMHz), .reset(reset), .en(csUnitsCarry), .clr(clrDigits),
    .q(cs_tens),     .carry(csTensCarry)
  );

  bcd_digit #(.MODULUS(10)) uSUnits (
    .clkMHz(clkMHz), .reset(reset), .en(csTensCarry),  .clr(clrDigits),
    .q(s_units),     .carry(sUnitsCarry)
  );

  bcd_digit #(.MODULUS(MAX_SEC / 10 + 1)) uSTens (
    .clkMHz(clkMHz), .reset(reset), .en(sTensEn),      .clr(clrDigits),
    .q(s_tens),      .carry(wrap)
  );

  // Sticky overflow: set on wrap, dropped only by clear or reset.
  always_ff @(posedge clkMHz) begin
    if (!reset)     ovf <= 1'b0;
    else if (clear) ovf <= 1'b0;
    else if (wrap)  ovf <= 1'b1;
  end

endmodule

// File: tb/tb_stopwatch_centi.sv
// Bench for stopwatch_centi: two instances (MAX_SEC 59 and 9) share stimulus and
// are compared against an elapsed-centiseconds reference model.
module tb_stopwatch_centi;

  logic       clkMHz = 1'b0;
  logic       reset, clkHz, start_stop, clear;
  logic [3:0] csU[2], csT[2], sU[2], sT[2];
  logic       runQ[2], ovfQ[2];

  always #10 clkMHz = ~clkMHz;

  stopwatch_centi #(.MAX_SEC(59)) dut59 (
    .clkMHz(clkMHz), .reset(reset), .clkHz(clkHz), .start_stop(start_stop), .clear(clear),
    .cs_units(csU[0]), .cs_tens(csT[0]), .s_units(sU[0]), .s_tens(sT[0]),
    .running(runQ[0]), .ovf(ovfQ[0])
  );

  stopwatch_centi #(.MAX_SEC(9)) dut9 (
    .clkMHz(clkMHz), .reset(reset), .clkHz(clkHz), .start_stop(start_stop), .clear(clear),
    .cs_units(csU[1]), .cs_tens(csT[1]), .s_units(sU[1]), .s_tens(sT[1]),
    .running(runQ[1]), .ovf(ovfQ[1])
  );

  int errors = 0;
  int checks = 0;

  // Reference model: elapsed time as a plain centisecond count, mode as 0/1/2.
  int cnt[2];
  bit ovfM[2];
  int mode[2];            // 0 idle, 1 running, 2 paused
  bit prevHz = 1'b1;
  int maxSec[2] = '{59, 9};

  function automatic void modelStep();
    bit tk;
    tk = clkHz && !prevHz;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        cnt[i] = 0; ovfM[i] = 0; mode[i] = 0;
      end else begin
        if (mode[i] == 1 && tk) begin
          cnt[i] = cnt[i] + 1;
          if (cnt[i] == (maxSec[i] + 1) * 100) begin
            cnt[i] = 0;
            ovfM[i] = 1;
          end
        end
        if (clear) begin
          cnt[i] = 0; ovfM[i] = 0; mode[i] = 0;
        end else if (start_stop) begin
          mode[i] = (mode[i] == 1) ? 2 : 1;
        end
      end
    end
    prevHz = reset ? clkHz : 1'b1;
  endfunction

  function automatic logic [17:0] expv(int i);
    int d;
    d = cnt[i];
    return {ovfM[i], (mode[i] == 1), 4'(d / 1000), 4'((d / 100) % 10),
            4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  function automatic logic [17:0] obs(int i);
    return {ovfQ[i], runQ[i], sT[i], sU[i], csT[i], csU[i]};
  endfunction

  // One clock: drive pulses, advance the model at the edge, sample 1 ns later.
  task automatic cyc(input logic ss, input logic clr);
    start_stop = ss;
    clear      = clr;
    @(posedge clkMHz);
    modelStep();
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
  endtask

  // n clkHz rising edges with random low/high widths.
  task automatic tickN(input int n);
    repeat (n) begin
      clkHz = 1'b0;
      repeat ($urandom_range(1, 2)) cyc(1'b0, 1'b0);
      clkHz = 1'b1;
      repeat ($urandom_range(1, 2)) cyc(1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    logic [17:0] o;
    reset = 1'b0;
    clkHz = 1'b1;
    repeat (3) cyc(1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      o = obs(i);
      checks++;
      if (o !== 18'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: got %h expected %h", i, o, 18'h0);
      end
    end
    reset = 1'b1;
    cyc(1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0);
    o = obs(0);
    checks++;
    if (o !== {2'b01, 16'h0000}) begin
      errors++;
      $display("FAIL reset_no_false_tick: got %h expected %h", o, {2'b01, 16'h0000});
    end
    clkHz = 1'b0; cyc(1'b0, 1'b0);
    clkHz = 1'b1; cyc(1'b0, 1'b0);
    o = obs(0);
    checks++;
    if (o !== {2'b01, 16'h0001}) begin
      errors++;
      $display("FAIL reset_first_tick: got %h expected %h", o, {2'b01, 16'h0001});
    end
    cyc(1'b0, 1'b1);
  endtask

  task automatic test_count();
    logic [17:0] o;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    tickN(123);
    o = obs(0);
    checks++;
    if (o !== {2'b01, 16'h0123}) begin
      errors++;
      $display("FAIL count_123: got %h expected %h", o, {2'b01, 16'h0123});
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== expv(i)) begin
        errors++;
        $display("FAIL count_model[%0d]: got %h expected %h", i, obs(i), expv(i));
      end
    end
  endtask

  task automatic test_pause();
    logic [17:0] o;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    tickN(50);
    cyc(1'b1, 1'b0);
    tickN(20);
    o = obs(0);
    checks++;
    if (o !== {2'b00, 16'h0050}) begin
      errors++;
      $display("FAIL pause_frozen: got %h expected %h", o, {2'b00, 16'h0050});
    end
    cyc(1'b1, 1'b0);
    tickN(5);
    o = obs(0);
    checks++;
    if (o !== {2'b01, 16'h0055}) begin
      errors++;
      $display("FAIL pause_resume: got %h expected %h", o, {2'b01, 16'h0055});
    end
  endtask

  task automatic test_coincide();
    logic [17:0] o;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    tickN(9);
    clkHz = 1'b0; cyc(1'b0, 1'b0);
    clkHz = 1'b1; cyc(1'b1, 1'b0);
    o = obs(0);
    checks++;
    if (o !== {2'b00, 16'h0010}) begin
      errors++;
      $display("FAIL tick_ss_in_run: got %h expected %h", o, {2'b00, 16'h0010});
    end
    clkHz = 1'b0; cyc(1'b0, 1'b0);
    clkHz = 1'b1; cyc(1'b1, 1'b0);
    o = obs(0);
    checks++;
    if (o !== {2'b01, 16'h0010}) begin
      errors++;
      $display("FAIL tick_ss_in_pause: got %h expected %h", o, {2'b01, 16'h0010});
    end
    clkHz = 1'b0; cyc(1'b0, 1'b0);
    clkHz = 1'b1; cyc(1'b1, 1'b1);
    tickN(3);
    for (int i = 0; i < 2; i++) begin
      o = obs(i);
      checks++;
      if (o !== 18'h0) begin
        errors++;
        $display("FAIL clear_beats_ss[%0d]: got %h expected %h", i, o, 18'h0);
      end
    end
  endtask

  task automatic test_wrap();
    logic [17:0] o;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    tickN(5999);
    o = obs(0);
    checks++;
    if (o !== {2'b01, 16'h5999}) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected %h", o, {2'b01, 16'h5999});
    end
    tickN(1);
    o = obs(0);
    checks++;
    if (o !== {2'b11, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_59: got %h expected %h", o, {2'b11, 16'h0000});
    end
    tickN(7);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs(i) !== expv(i)) begin
        errors++;
        $display("FAIL wrap_sticky[%0d]: got %h expected %h", i, obs(i), expv(i));
      end
    end
    cyc(1'b0, 1'b1);
    o = obs(0);
    checks++;
    if (o !== 18'h0) begin
      errors++;
      $display("FAIL wrap_clear_ovf: got %h expected %h", o, 18'h0);
    end
  endtask

  task automatic test_max9();
    logic [17:0] o;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    tickN(999);
    o = obs(1);
    checks++;
    if (o !== {2'b01, 16'h0999}) begin
      errors++;
      $display("FAIL max9_preload: got %h expected %h", o, {2'b01, 16'h0999});
    end
    tickN(1);
    o = obs(1);
    checks++;
    if (o !== {2'b11, 16'h0000}) begin
      errors++;
      $display("FAIL max9_wrap: got %h expected %h", o, {2'b11, 16'h0000});
    end
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      clkHz = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 499) != 0);
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 149) == 0));
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs(i) !== expv(i)) begin
          errors++;
          bad++;
          if (bad <= 10)
            $display("FAIL random[%0d] cycle %0d: got %h expected %h", i, n, obs(i), expv(i));
        end
      end
    end
    reset = 1'b1;
  endtask

  initial begin
    reset      = 1'b0;
    clkHz      = 1'b1;
    start_stop = 1'b0;
    clear      = 1'b0;
    test_reset();
    test_count();
    test_pause();
    test_coincide();
    test_wrap();
    test_max9();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
